// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 codes and the
// data-memory responder state encoding.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_lsu_format.sv
// Combinational load/store lane formatter: byte enables, store lane
// replication, load extension and misaligned/illegal detection.
module dmem_lsu_format
    import riscv_pkg::*;
(
    input  logic        write_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign shifted = rword_i >> {lane_i, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Decode access size, lane placement and extension from funct3.
    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = 32'd0;
        rdata_o      = 32'd0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        if (write_i) begin
            case (funct3_i)
                F3_SB: begin
                    be_o    = 4'b0001 << lane_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_SH: begin
                    be_o         = lane_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o      = {2{wdata_i[15:0]}};
                    misaligned_o = lane_i[0];
                end
                F3_SW: begin
                    be_o         = 4'b1111;
                    wdata_o      = wdata_i;
                    misaligned_o = |lane_i;
                end
                default: illegal_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_LB:  rdata_o = {{24{byte_v[7]}}, byte_v};
                F3_LBU: rdata_o = {24'd0, byte_v};
                F3_LH: begin
                    rdata_o      = {{16{half_v[15]}}, half_v};
                    misaligned_o = lane_i[0];
                end
                F3_LHU: begin
                    rdata_o      = {16'd0, half_v};
                    misaligned_o = lane_i[0];
                end
                F3_LW: begin
                    rdata_o      = rword_i;
                    misaligned_o = |lane_i;
                end
                default: illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave with fixed response latency and error responses.
// Optional DMEM_BOUNDS_CHECK_EN rejects addresses beyond DEPTH words.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [31:0] mem_q [DEPTH];

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   fmt_wdata;
    logic [31:0]   fmt_rdata;
    logic          mis;
    logic          ill;
    logic          oor;
    logic          err;
    logic          accept;
    logic          we;

    assign idx   = req_addr_i[AW+1:2];
    assign rword = mem_q[idx];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oor = (req_addr_i >> (AW + 2)) != 32'd0;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:AW+2];
    assign oor = 1'b0;
`endif

    dmem_lsu_format u_fmt (
        .write_i      (req_write_i),
        .funct3_i     (req_funct3_i),
        .lane_i       (req_addr_i[1:0]),
        .wdata_i      (req_wdata_i),
        .rword_i      (rword),
        .be_o         (be),
        .wdata_o      (fmt_wdata),
        .rdata_o      (fmt_rdata),
        .misaligned_o (mis),
        .illegal_o    (ill)
    );

    assign req_ready_o = (state_q == DMEM_IDLE);
    assign rsp_valid_o = (state_q == DMEM_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign err    = mis | ill | oor;
    assign accept = req_valid_i & req_ready_o & ~reset_i;
    assign we     = accept & req_write_i & ~err;

    // Next-state logic: capture the response on accept, count, hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            DMEM_IDLE: begin
                if (accept) begin
                    rdata_d = (req_write_i | err) ? 32'd0 : fmt_rdata;
                    err_d   = err;
                    if (LATENCY == 1) begin
                        state_d = DMEM_RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DMEM_RESP;
                end
            end
            DMEM_RESP: begin
                if (rsp_ready_i) begin
                    state_d = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-masked RAM write on the accept edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= fmt_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave serving load/store requests issued by the CPU memory stage over a valid/ready request and response handshake.
- Owns a word-organised RAM and performs byte/half/word access selection from funct3, plus sign/zero extension of loads.
- Flags misaligned and illegal accesses with an error response.
- Has a programmable fixed response latency so the pipeline stall logic can be exercised.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 1, cycles from request acceptance to rsp_valid_o; range 1..15.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept a request
- req_write_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data; the operand sits in the low bits
- req_funct3_i  in  3  RV32I load/store funct3
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  requester accepts the response
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned, illegal funct3, or out-of-range access

Behaviour:
- Single clock domain; every flop is updated on the rising edge of clk_i, and reset_i is sampled there.
- Reset values:
  - state = IDLE; req_ready_o = 1 in the first cycle after reset.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
  - Latency counter = 0.
  - RAM contents are not reset.
- States and transitions:
  - IDLE: req_ready_o = 1. Accept when req_valid_i & req_ready_o. On accept, go to RESP if LATENCY = 1, otherwise load the counter with LATENCY-1 and go to WAIT.
  - WAIT: req_ready_o = 0. Decrement the counter each cycle; go to RESP on the cycle the counter reaches 0.
  - RESP: rsp_valid_o = 1 and req_ready_o = 0. Data and error stay stable until rsp_ready_i = 1, then return to IDLE. There is no accept in the same cycle; the next accept is possible one cycle after the handshake.
- The RAM is read or written on the accept edge. The formatted result is registered into a holding register and presented unchanged in RESP.
- Word index = req_addr_i[log2(DEPTH)+1:2]; byte lane = req_addr_i[1:0].
- Loads:
  - LB (000) / LBU (100): select byte lane, sign- or zero-extend.
  - LH (001) / LHU (101): select half at addr[1], sign- or zero-extend.
  - LW (010): full word.
- Stores: the write uses a byte-enable mask.
  - SB (000): one byte, replicated req_wdata_i[7:0] into the addressed lane.
  - SH (001): two bytes, at addr[1].
  - SW (010): all four bytes.
- Errors:
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Out of range: see Optional Feature.
  - On any error: no RAM write, rsp_err_o = 1, rsp_rdata_o = 0.
- rsp_valid_o for a store still occurs; this is the write acknowledge.
- Back-to-back: throughput is one request per LATENCY+1 cycles when rsp_ready_i is held high.
- Reset mid-operation: the state returns to IDLE and any pending response is discarded. A store accepted before the reset stays committed.
- A request held while req_ready_o = 0 is neither accepted nor sampled.

Optional Feature:
- DMEM_BOUNDS_CHECK_EN defined: an address with req_addr_i[31:log2(DEPTH)+2] != 0 returns rsp_err_o = 1 and performs no write.
- Undefined: the upper address bits are ignored and the access wraps modulo DEPTH words.

Decomposition:
- Shared package (riscv_pkg):
  - funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - State enum: DMEM_IDLE, DMEM_WAIT, DMEM_RESP.
- One sub-module, dmem_lsu_format: purely combinational. It generates the byte-enable and store-lane data, extends load data, and computes the misaligned/illegal flags. It is reused later by the load-store unit.

Test Plan:
- LATENCY=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata_o = 0xDEADBEEF, rsp_err_o = 0; rsp_valid_o rises exactly 1 cycle after each accept.
- After word 0x80808080 at 0x20: LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; LH 0x22 -> 0xFFFF8080; LHU 0x22 -> 0x00008080.
- SB 0x31 data 0x000000AA over word 0x11223344 at 0x30, then LW 0x30 -> 0x1122AA44.
- LW 0x13 -> rsp_err_o = 1, rsp_rdata_o = 0. SH 0x15 -> err and memory unchanged. Load funct3 = 111 -> err.
- LATENCY=4, rsp_ready_i held low 3 cycles:
  - req_ready_o = 0 from accept until 1 cycle after the handshake.
  - rsp_valid_o rises 4 cycles after accept, and data holds stable while stalled.
- Assert reset_i in WAIT: the next cycle has rsp_valid_o = 0 and req_ready_o = 1. A prior committed store is still readable.
- Out-of-range access:
  - With DMEM_BOUNDS_CHECK_EN, DEPTH=1024: SW 0x1000 -> err and word 0 unchanged.
  - Without the macro: the same store overwrites word 0.
